clock_step_ctrl: RTL and testbench



---
 rtl/clock_step_ctrl.sv | 97 +++++++++
 tb/tb_clock_step_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/clock_step_ctrl.sv
// clock_step_ctrl: turns clk_div edges / a debounced step button into single-cycle cpu_en pulses (ports: clk, rst, clk_div, mode_sel, step_btn -> cpu_en, running, step_count; CLOCK_STEP_CTRL_BREAK_EN adds pc, brk_addr, brk_valid -> break_hit)
module clock_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_div,
  input  logic [1:0]         mode_sel,
  input  logic               step_btn,
`ifdef CLOCK_STEP_CTRL_BREAK_EN
  input  logic [3:0]         pc,
  input  logic [3:0]         brk_addr,
  input  logic               brk_valid,
  output logic               break_hit,
`endif
  output logic               cpu_en,
  output logic               running,
  output logic [COUNT_W-1:0] step_count
);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
`ifdef CLOCK_STEP_CTRL_BREAK_EN
  typedef enum logic [2:0] {HALT, AUTO_SLOW, AUTO_FAST, MAN_IDLE, MAN_HELD, BREAK} state_t;
  state_t ret_q;
`else
  typedef enum logic [2:0] {HALT, AUTO_SLOW, AUTO_FAST, MAN_IDLE, MAN_HELD} state_t;
`endif
  state_t state, state_nxt, mode_st;
  logic [1:0] mode_q;
  logic clk_div_d, btn_m, btn_s, btn_db, press, en_nxt, rise, any_edge, auto_fire, db_diff, db_done;
  logic [DW-1:0] cnt;
  assign rise = clk_div & ~clk_div_d;
  assign any_edge = clk_div ^ clk_div_d;
  assign db_diff = btn_s ^ btn_db;
  assign db_done = db_diff && cnt == DW'(DEBOUNCE_CYCLES - 1);
  assign auto_fire = (state == AUTO_SLOW && rise) || (state == AUTO_FAST && any_edge);
  assign mode_st = mode_q == 2'b01 ? AUTO_SLOW : mode_q == 2'b10 ? AUTO_FAST :
                   mode_q == 2'b11 ? (btn_db ? MAN_HELD : MAN_IDLE) : HALT;
  // Transitions come from mode_q first; pulses are judged by the current state so a
  // simultaneous mode change never drops or doubles a pulse.
  always_comb begin
    state_nxt = mode_st;
    en_nxt = 1'b0;
    if (state == MAN_IDLE && mode_q == 2'b11) begin
      state_nxt = press ? MAN_HELD : MAN_IDLE;
      en_nxt = press;
    end else if (state == MAN_HELD && mode_q == 2'b11)
      state_nxt = btn_db ? MAN_HELD : MAN_IDLE;
`ifdef CLOCK_STEP_CTRL_BREAK_EN
    else if (state == BREAK && mode_q == (ret_q == AUTO_SLOW ? 2'b01 : 2'b10)) begin
      state_nxt = press ? ret_q : BREAK;
      en_nxt = press;
    end else if (auto_fire && !(brk_valid && pc == brk_addr))
      en_nxt = 1'b1;
    else if (auto_fire && !cpu_en)
      state_nxt = BREAK;
`else
    else if (auto_fire)
      en_nxt = 1'b1;
`endif
    en_nxt = en_nxt & ~cpu_en;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= '0;
      clk_div_d <= 1'b0;
      {btn_m, btn_s, btn_db, press} <= '0;
      cnt <= '0;
      state <= HALT;
      cpu_en <= 1'b0;
      running <= 1'b0;
      step_count <= '0;
    end else begin
      mode_q <= mode_sel;
      clk_div_d <= clk_div;
      {btn_s, btn_m} <= {btn_m, step_btn};
      cnt <= (db_diff && !db_done) ? cnt + 1'b1 : '0;
      btn_db <= db_done ? btn_s : btn_db;
      press <= db_done & btn_s;
      state <= state_nxt;
      cpu_en <= en_nxt;
      running <= state_nxt == AUTO_SLOW || state_nxt == AUTO_FAST;
      step_count <= step_count + COUNT_W'(en_nxt);
    end
  end
`ifdef CLOCK_STEP_CTRL_BREAK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ret_q <= AUTO_SLOW;
      break_hit <= 1'b0;
    end else begin
      ret_q <= (state_nxt == BREAK && state != BREAK) ? state : ret_q;
      break_hit <= state_nxt == BREAK;
    end
  end
`endif
endmodule

// File: tb/tb_clock_step_ctrl.sv
// tb_clock_step_ctrl: scoreboard bench for clock_step_ctrl (expected pulse cycles queued at stimulus time)
module tb_clock_step_ctrl;
  logic clk = 1'b0, rst = 1'b1, clk_div = 1'b0, step_btn = 1'b0;
  logic [1:0] mode_sel = 2'b00;
  logic cpu_en, running;
  logic [7:0] step_count;
`ifdef CLOCK_STEP_CTRL_BREAK_EN
  logic [3:0] pc = 4'd0, brk_addr = 4'd0;
  logic brk_valid = 1'b0, break_hit;
`endif
  int total = 0, bad = 0, cyc = 0;
  int exp_q[$];
  logic prev_en = 1'b0;

  clock_step_ctrl #(.DEBOUNCE_CYCLES(4), .COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .clk_div(clk_div), .mode_sel(mode_sel), .step_btn(step_btn),
`ifdef CLOCK_STEP_CTRL_BREAK_EN
    .pc(pc), .brk_addr(brk_addr), .brk_valid(brk_valid), .break_hit(break_hit),
`endif
    .cpu_en(cpu_en), .running(running), .step_count(step_count));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cpu_en) begin
      chk("width", int'(prev_en), 0);
      if (exp_q.size() == 0) chk("extra", cyc, -1);
      else chk("lat", cyc, exp_q.pop_front());
    end
    prev_en = cpu_en;
  end

  task automatic do_reset();
    rst = 1'b1;
    clk_div = 1'b0;
    step_btn = 1'b0;
    mode_sel = 2'b00;
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic run_div(input int period, input int ncyc, input bit fast);
    bit nv;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (i % period == 0) begin
        nv = !clk_div;
        if (fast || nv) exp_q.push_back(cyc + 1);
        clk_div = nv;
      end
    end
  endtask

  // bounce optionally, then steady high 8 cycles (pulse expected 7 edges later), then low
  task automatic press_btn(input bit bounce, input bit expect_pulse);
    if (bounce)
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        step_btn = (i % 2 == 0);
      end
    @(negedge clk);
    step_btn = 1'b1;
    if (expect_pulse) exp_q.push_back(cyc + 7);
    repeat (8) @(negedge clk);
    step_btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    do_reset();
    chk("rst_en", int'(cpu_en), 0);
    chk("rst_run", int'(running), 0);
    chk("rst_cnt", int'(step_count), 0);

    mode_sel = 2'b01;
    repeat (3) @(negedge clk);
    run_div(10, 100, 1'b0);
    repeat (3) @(negedge clk);
    chk("slow_cnt", int'(step_count), 5);
    chk("slow_run", int'(running), 1);
    chk("slow_miss", exp_q.size(), 0);

    do_reset();
    mode_sel = 2'b10;
    repeat (3) @(negedge clk);
    run_div(10, 100, 1'b1);
    repeat (3) @(negedge clk);
    chk("fast_cnt", int'(step_count), 10);
    chk("fast_run", int'(running), 1);
    chk("fast_miss", exp_q.size(), 0);

    do_reset();
    mode_sel = 2'b11;
    repeat (3) @(negedge clk);
    press_btn(1'b1, 1'b1);
    chk("man_cnt", int'(step_count), 1);
    chk("man_run", int'(running), 0);
    chk("man_miss", exp_q.size(), 0);

    do_reset();
    step_btn = 1'b1;
    repeat (12) @(negedge clk);
    mode_sel = 2'b11;
    repeat (12) @(negedge clk);
    chk("held_cnt", int'(step_count), 0);
    step_btn = 1'b0;
    repeat (12) @(negedge clk);
    press_btn(1'b0, 1'b1);
    chk("held_cnt2", int'(step_count), 1);
    chk("held_miss", exp_q.size(), 0);

    do_reset();
    mode_sel = 2'b01;
    repeat (3) @(negedge clk);
    run_div(2, 1020, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre_wrap", int'(step_count), 255);
    run_div(2, 2, 1'b0);
    repeat (3) @(negedge clk);
    chk("wrap", int'(step_count), 0);
    chk("wrap_miss", exp_q.size(), 0);
    @(negedge clk);
    clk_div = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_en", int'(cpu_en), 0);
    chk("mid_rst_run", int'(running), 0);
    chk("mid_rst_cnt", int'(step_count), 0);
    rst = 1'b0;
    clk_div = 1'b0;
    repeat (3) @(negedge clk);

`ifdef CLOCK_STEP_CTRL_BREAK_EN
    do_reset();
    brk_valid = 1'b1;
    brk_addr = 4'd3;
    pc = 4'd3;
    mode_sel = 2'b01;
    repeat (3) @(negedge clk);
    clk_div = 1'b1;
    repeat (2) @(negedge clk);
    chk("brk_hit", int'(break_hit), 1);
    chk("brk_run", int'(running), 0);
    chk("brk_cnt", int'(step_count), 0);
    press_btn(1'b0, 1'b1);
    chk("brk_resume_run", int'(running), 1);
    chk("brk_resume_hit", int'(break_hit), 0);
    chk("brk_resume_cnt", int'(step_count), 1);
    chk("brk_miss", exp_q.size(), 0);
    brk_valid = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end
endmodule
